data_mem_access_unit: RTL and testbench



---
 rtl/data_mem_access_unit_if.sv | 30 +++
 rtl/data_mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_access_unit_if.sv
// Request/response handshake and word-wide data bus of the data memory access unit.
// slave is the unit itself; master is everything around it (requester and memory).
interface data_mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        data_waitrequest;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, data_readdata, data_waitrequest,
        output req_ready, resp_valid, resp_rdata, resp_error,
               data_address, data_read, data_write, data_writedata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, data_readdata, data_waitrequest,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               data_address, data_read, data_write, data_writedata
    );
endinterface

// File: rtl/data_mem_access_unit.sv
// Load/store initiator for a word-wide little-endian data bus: lane extraction with
// extension for loads, read-modify-write for sub-word stores, misalignment rejection.
module data_mem_access_unit #(
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input logic                    clk,
    input logic                    reset_n,
    data_mem_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [31:0] TO_LAST = (WAIT_TIMEOUT == 0) ? 32'd0 : WAIT_TIMEOUT - 32'd1;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic [31:0] r_address;
    logic [31:0] r_writedata;
    logic [31:0] r_rdata;
    logic        r_error;
    logic [31:0] r_cnt;

    logic        w_misaligned;
    logic        w_sub_store;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_rep;
    logic [31:0] w_merged;

    always_comb begin
        w_misaligned = 1'b0;
        case (bus.req_op)
            OP_LH, OP_LHU, OP_SH: w_misaligned = bus.req_addr[0];
            OP_LW, OP_SW:         w_misaligned = (bus.req_addr[1:0] != 2'b00);
            default:              w_misaligned = 1'b0;
        endcase
    end

    assign w_sub_store = (r_op == OP_SB) || (r_op == OP_SH);
    assign w_timeout   = (WAIT_TIMEOUT != 0) && (r_cnt == TO_LAST);

    always_comb begin
        w_byte = bus.data_readdata[7:0];
        case (r_lane)
            2'd1:    w_byte = bus.data_readdata[15:8];
            2'd2:    w_byte = bus.data_readdata[23:16];
            2'd3:    w_byte = bus.data_readdata[31:24];
            default: w_byte = bus.data_readdata[7:0];
        endcase
        w_half = r_lane[1] ? bus.data_readdata[31:16] : bus.data_readdata[15:0];
        case (r_op)
            OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load = {24'd0, w_byte};
            OP_LH:   w_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load = {16'd0, w_half};
            OP_LW:   w_load = bus.data_readdata;
            default: w_load = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so each merged byte just picks old or new.
    always_comb begin
        w_be  = 4'b0000;
        w_rep = {2{r_wdata}};
        if (r_op == OP_SB) begin
            w_be  = 4'b0001 << r_lane;
            w_rep = {4{r_wdata[7:0]}};
        end else if (r_op == OP_SH) begin
            w_be  = r_lane[1] ? 4'b1100 : 4'b0011;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign w_merged[gi*8 +: 8] = w_be[gi] ? w_rep[gi*8 +: 8] : bus.data_readdata[gi*8 +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= 3'd0;
            r_lane      <= 2'd0;
            r_wdata     <= 16'd0;
            r_address   <= 32'd0;
            r_writedata <= 32'd0;
            r_rdata     <= 32'd0;
            r_error     <= 1'b0;
            r_cnt       <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op      <= bus.req_op;
                        r_lane    <= bus.req_addr[1:0];
                        r_wdata   <= bus.req_wdata[15:0];
                        r_address <= {bus.req_addr[31:2], 2'b00};
                        r_cnt     <= 32'd0;
                        if (w_misaligned) begin
                            r_error <= 1'b1;
                            r_rdata <= 32'd0;
                            r_state <= S_RESP;
                        end else if (bus.req_op == OP_SW) begin
                            r_writedata <= bus.req_wdata;
                            r_state     <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (!bus.data_waitrequest) begin
                        if (w_sub_store) begin
                            r_writedata <= w_merged;
                            r_cnt       <= 32'd0;
                            r_state     <= S_WRITE;
                        end else begin
                            r_rdata <= w_load;
                            r_error <= 1'b0;
                            r_state <= S_RESP;
                        end
                    end else if (w_timeout) begin
                        // A timed-out RMW read abandons the store entirely.
                        r_rdata <= 32'd0;
                        r_error <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_WRITE: begin
                    if (!bus.data_waitrequest) begin
                        r_rdata <= 32'd0;
                        r_error <= 1'b0;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_rdata <= 32'd0;
                        r_error <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready      = (r_state == S_IDLE);
    assign bus.resp_valid     = (r_state == S_RESP);
    assign bus.resp_rdata     = r_rdata;
    assign bus.resp_error     = r_error;
    assign bus.data_address   = r_address;
    assign bus.data_read      = (r_state == S_READ);
    assign bus.data_write     = (r_state == S_WRITE);
    assign bus.data_writedata = r_writedata;
endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with a small word memory behind the bus
// and a scoreboard of expected responses.
module tb_data_mem_access_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_access_unit_if bus ();

    data_mem_access_unit #(.WAIT_TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;

    assign bus.data_readdata = mem[bus.data_address[5:2]];

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_idx] <= pre_val;
        else if (bus.data_write && !bus.data_waitrequest)
            mem[bus.data_address[5:2]] <= bus.data_writedata;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [31:0] wword;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference merge of a sub-word store into a little-endian word.
    function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] lane,
                                          input logic [31:0] w, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        if (op == 3'd5) r[int'(lane)*8 +: 8] = wd[7:0];
        if (op == 3'd6) r[int'(lane[1])*16 +: 16] = wd[15:0];
        return r;
    endfunction

    // waits < 0 means waitrequest is held high until the unit gives up.
    task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rdata, input int waits);
        exp_t e, got;
        bit   mis, stuck, done;
        int   acc, n_rd, n_wr, lat, wait_left;
        mis = ((op == 3'd1 || op == 3'd4 || op == 3'd6) && addr[0]) ||
              ((op == 3'd2 || op == 3'd7) && addr[1:0] != 2'b00);
        stuck = (waits < 0);
        wait_left = stuck ? 1000 : waits;
        e.rdata = exp_rdata;
        e.err   = mis || stuck;
        e.wword = 32'd0;
        if (mis) begin
            e.lat = 1; e.n_rd = 0; e.n_wr = 0;
        end else if (op == 3'd7) begin
            e.lat = 2 + waits; e.n_rd = 0; e.n_wr = 1 + waits; e.wword = wd;
        end else if (op == 3'd5 || op == 3'd6) begin
            e.lat = 3 + waits; e.n_rd = 1 + waits; e.n_wr = stuck ? 0 : 1;
            e.wword = merge(op, addr[1:0], ref_mem[addr[5:2]], wd);
        end else begin
            e.lat = 2 + waits; e.n_rd = 1 + waits; e.n_wr = 0;
        end
        if (!e.err && op >= 3'd5) ref_mem[addr[5:2]] = e.wword;
        sbq.push_back(e);

        @(negedge clk);
        check({"ready_", tag}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
        n_rd = 0; n_wr = 0; lat = 0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bus.data_read || bus.data_write) begin
                if (bus.data_read) n_rd++;
                if (bus.data_write) begin
                    n_wr++;
                    check({"wdata_", tag}, bus.data_writedata, e.wword);
                end
                check({"addr_", tag}, bus.data_address, {addr[31:2], 2'b00});
                bus.data_waitrequest = (wait_left > 0);
                if (wait_left > 0) wait_left--;
            end else begin
                bus.data_waitrequest = 1'b0;
            end
            if (bus.resp_valid) begin
                done = 1'b1;
                lat = cyc - acc + 1;
                check({"strobes_in_resp_", tag}, {30'd0, bus.data_read, bus.data_write}, 32'd0);
            end
        end
        bus.data_waitrequest = 1'b0;
        if (!done) begin
            check({"resp_timeout_", tag}, 32'd0, 32'd1);
            void'(sbq.pop_front());
        end else begin
            got = sbq.pop_front();
            check({"rdata_", tag}, bus.resp_rdata, got.rdata);
            check({"err_", tag}, {31'd0, bus.resp_error}, {31'd0, got.err});
            check({"nwr_", tag}, n_wr, got.n_wr);
            if (!stuck) begin
                check({"lat_", tag}, lat, got.lat);
                check({"nrd_", tag}, n_rd, got.n_rd);
            end
        end
        $display("txn %s op=%0d addr=%h wdata=%h rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 tag, op, addr, wd, bus.resp_rdata, bus.resp_error, lat, n_rd, n_wr);
    endtask

    initial begin
        bit seen_wr;
        bus.req_valid = 1'b0;
        bus.req_op = 3'd0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        bus.data_waitrequest = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
        pre_en = 1'b1; pre_idx = 4'd4; pre_val = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;
        repeat (2) @(posedge clk);
        #1;
        pre_en = 1'b0;

        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_strobes", {30'd0, bus.data_read, bus.data_write}, 32'd0);
        check("rst_address", bus.data_address, 32'd0);
        check("rst_writedata", bus.data_writedata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_req("lw_10",  3'd2, 32'h10, 32'd0, 32'h8899AABB, 0);
        run_req("lb_13",  3'd0, 32'h13, 32'd0, 32'hFFFFFF88, 0);
        run_req("lbu_13", 3'd3, 32'h13, 32'd0, 32'h00000088, 0);
        run_req("lh_12",  3'd1, 32'h12, 32'd0, 32'hFFFF8899, 0);
        run_req("lhu_10", 3'd4, 32'h10, 32'd0, 32'h0000AABB, 0);
        run_req("lb_10",  3'd0, 32'h10, 32'd0, 32'hFFFFFFBB, 0);
        run_req("lbu_11", 3'd3, 32'h11, 32'd0, 32'h000000AA, 0);
        run_req("sb_11",  3'd5, 32'h11, 32'h123456CC, 32'd0, 0);
        run_req("lw_10b", 3'd2, 32'h10, 32'd0, 32'h8899CCBB, 0);
        run_req("sh_13",  3'd6, 32'h13, 32'h0000BEEF, 32'd0, 0);
        run_req("lw_12",  3'd2, 32'h12, 32'd0, 32'd0, 0);
        run_req("lhu_11", 3'd4, 32'h11, 32'd0, 32'd0, 0);
        run_req("lw_wait2", 3'd2, 32'h10, 32'd0, 32'h8899CCBB, 2);
        run_req("sb_stuck", 3'd5, 32'h10, 32'h00000077, 32'd0, -1);
        run_req("lw_after_to", 3'd2, 32'h10, 32'd0, 32'h8899CCBB, 0);
        run_req("sw_14",  3'd7, 32'h14, 32'hDEADBEEF, 32'd0, 0);
        run_req("sh_16",  3'd6, 32'h16, 32'h00001234, 32'd0, 0);
        run_req("lw_14",  3'd2, 32'h14, 32'd0, 32'h1234BEEF, 0);
        run_req("lh_16",  3'd1, 32'h16, 32'd0, 32'h00001234, 0);
        run_req("lb_15",  3'd0, 32'h15, 32'd0, 32'hFFFFFFBE, 0);

        // Reset while the RMW write phase is on the bus.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'd6; bus.req_addr = 32'h12; bus.req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        seen_wr = 1'b0;
        for (int k = 0; k < 10 && !seen_wr; k++) begin
            @(negedge clk);
            if (bus.data_write) seen_wr = 1'b1;
        end
        check("rst_mid_saw_write", {31'd0, seen_wr}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_write_drop", {31'd0, bus.data_write}, 32'd0);
        check("rst_mid_read_drop", {31'd0, bus.data_read}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        end
        reset_n = 1'b1;
        #1;
        check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_mid_mem_intact", mem[4], 32'h8899CCBB);
        run_req("lw_after_rst", 3'd2, 32'h10, 32'd0, 32'h8899CCBB, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
